soc_ram_arb: RTL and testbench
==============================

Name: soc_ram_arb

Overview:
- Two-requester arbiter that shares one single-port synchronous FPGA RAM between an instruction-side master (requester 0) and a data/debug-side master (requester 1).
- Issues at most one RAM access per cycle.
- Returns read data one cycle after the access, tagged to the requester that issued it.
- Supports a lock so one requester can run an uninterrupted read-modify-write sequence.

Parameters:
- DATAWIDTH, 32, RAM word width and requester data width.
- ADDRWIDTH, 14, RAM word-address width.
- LOCK_MAX, 15, maximum consecutive granted cycles under lock before lock is forcibly broken (≥1).

Ports:
- clk  input  1  single clock for arbiter and RAM.
- rst_b  input  1  asynchronous active-low reset.
- req0_vld  input  1  requester 0 access request.
- req0_we  input  1  1 = write, 0 = read.
- req0_lock  input  1  hold ownership after this grant.
- req0_addr  input  ADDRWIDTH  word address.
- req0_wdata  input  DATAWIDTH  write data.
- req0_gnt  output  1  access accepted this cycle.
- req0_rvld  output  1  read data valid.
- req0_rdata  output  DATAWIDTH  read data.
- req1_*: same set as requester 0.
- ram_addr  output  ADDRWIDTH  to RAM address.
- ram_wdata  output  DATAWIDTH  to RAM write data.
- ram_we  output  1  to RAM write enable.
- ram_rdata  input  DATAWIDTH  from RAM read data (registered inside RAM).
- arb_busy  output  1  a RAM access is issued this cycle or a read is returning.

Behaviour:
- One clock (clk); reset rst_b is asynchronous, active-low. All state regs clear on rst_b low regardless of clk.
- Reset values: last_gnt=1 (so requester 0 wins first tie), lock_own=NONE, lock_cnt=0, rd_pend=0, rd_tag=0. All gnt/rvld outputs 0; rdata outputs 0; ram_we 0.
- Grant is combinational in the same cycle as req*_vld. Handshake completes when vld&gnt. A requester holds vld, we, addr and wdata stable until gnt.
- Arbitration with no lock: if only one vld, grant it. If both, grant !last_gnt (round robin). last_gnt updates on every grant.
- RAM port drive: ram_addr/ram_wdata/ram_we are muxed combinationally from the granted requester. With no grant, ram_we=0 and ram_addr holds the last driven value, to avoid spurious reads changing output.
- RAM semantics: a read grant in cycle T returns data on ram_rdata in T+1. A write does not update ram_rdata.
- Read return: a read grant sets rd_pend=1 and rd_tag=winner for T+1. In T+1, reqN_rvld=1 only for N=rd_tag, and reqN_rdata=ram_rdata.
- rdata is registered-held: each reqN_rdata keeps its last returned value until its next rvld.
- Back-to-back reads are fully pipelined, one per cycle. rvld of the previous access and gnt of the next can be in the same cycle.
- Lock FSM states: UNLOCKED, LOCK0, LOCK1.
  - UNLOCKED→LOCKn on a grant to n with reqn_lock=1.
  - In LOCKn only requester n can be granted. The other requester's gnt=0 even if n is idle.
  - LOCKn→UNLOCKED on a grant to n with reqn_lock=0, or when lock_cnt reaches LOCK_MAX.
  - lock_cnt increments every cycle spent in LOCKn and clears on exit.
  - On forced exit, last_gnt=n, so the other requester wins the next tie.
  - While in LOCKn, reqn_lock deasserted without vld has no effect; only a granted access releases the lock.
- Read-after-write to the same address in consecutive cycles returns the new data. The RAM commits the write at the edge before the read is sampled, so no bypass is needed.
- arb_busy = any gnt | rd_pend.
- Reset asserted mid-read: the pending rvld is dropped and never delivered.

Optional Feature:
- Macro: SOC_RAM_ARB_FIXED_PRI_EN.
- Defined: requester 1 (data/debug) always wins simultaneous requests. last_gnt is unused and removed. The lock FSM and LOCK_MAX timeout are unchanged.
- Undefined: round-robin as above.

Decomposition:
- Shared package soc_ram_arb_pkg holds:
  - lock-state enum: UNLOCKED=2'd0, LOCK0=2'd1, LOCK1=2'd2;
  - requester id constants REQ0=1'b0, REQ1=1'b1;
  - default LOCK_MAX.
- One natural sub-module, soc_ram_arb_rr: a 2-way pick that takes vld[1:0], last_gnt and the lock state, and returns a one-hot grant. Fixed-priority selection lives there under the macro.
- The top level holds the RAM mux, read-tag pipeline and lock counter.

Test Plan:
- Reset/idle: rst_b low 3 cycles, no requests → all gnt/rvld 0, ram_we 0, arb_busy 0. Assert rst_b low asynchronously mid-cycle → outputs clear before the next edge.
- Single write then read: req0 writes 0xDEADBEEF @0x0010 (gnt same cycle, ram_we=1), then reads 0x0010 → req0_rvld=1 one cycle later with rdata 0xDEADBEEF; req1_rvld stays 0.
- Contention round robin: both vld reading 0x0001/0x0002 for 4 cycles → grants alternate 0,1,0,1 (starting with 0 after reset); rvld tags alternate one cycle later with the correct data. With SOC_RAM_ARB_FIXED_PRI_EN → req1 granted all 4 cycles.
- Lock RMW: req1 read 0x0100 with lock=1, then write 0x0100 with lock=0 while req0 is continuously valid → req0_gnt=0 for both cycles and granted on the third.
- Lock timeout: req0 lock=1 held with vld pulsed; LOCK_MAX=15 → after 15 locked cycles the FSM returns to UNLOCKED and pending req1 is granted the next cycle.
- Pipelined reads: req0 reads 0..7 back-to-back → 8 consecutive rvld cycles, each returning mem[i]; arb_busy high for 9 cycles.

Source files
------------

// File: rtl/soc_ram_arb_pkg.sv
// Shared types and constants for the two-requester RAM arbiter.
package soc_ram_arb_pkg;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    LOCK0    = 2'd1,
    LOCK1    = 2'd2
  } lock_e;

  localparam logic REQ0         = 1'b0;
  localparam logic REQ1         = 1'b1;
  localparam int   LOCK_MAX_DEF = 15;

endpackage

// File: rtl/soc_ram_arb_rr.sv
// Two-way grant pick: honours lock ownership, then breaks ties by round robin.
// SOC_RAM_ARB_FIXED_PRI_EN: requester 1 always wins ties and last_gnt is dropped.
module soc_ram_arb_rr
  import soc_ram_arb_pkg::*;
(
  input  logic [1:0] vld,
`ifndef SOC_RAM_ARB_FIXED_PRI_EN
  input  logic       last_gnt,
`endif
  input  lock_e      lock_st,
  output logic [1:0] gnt
);

  logic tie_win;

`ifdef SOC_RAM_ARB_FIXED_PRI_EN
  assign tie_win = REQ1;
`else
  assign tie_win = ~last_gnt;
`endif

  // A locked owner excludes the other side even while it is idle
  always_comb begin
    gnt = 2'b00;
    case (lock_st)
      LOCK0:   gnt[0] = vld[0];
      LOCK1:   gnt[1] = vld[1];
      default: begin
        if (&vld) gnt[tie_win] = 1'b1;
        else      gnt          = vld;
      end
    endcase
  end

endmodule

// File: rtl/soc_ram_arb.sv
// Shares one single-port synchronous RAM between two requesters: one access
// per cycle, read data tagged back one cycle later, optional lock for RMW.
// SOC_RAM_ARB_FIXED_PRI_EN selects fixed priority (requester 1) for ties.
module soc_ram_arb
  import soc_ram_arb_pkg::*;
#(
  parameter int DATAWIDTH = 32,
  parameter int ADDRWIDTH = 14,
  parameter int LOCK_MAX  = LOCK_MAX_DEF
) (
  input  logic                 clk,
  input  logic                 rst_b,
  input  logic                 req0_vld,
  input  logic                 req0_we,
  input  logic                 req0_lock,
  input  logic [ADDRWIDTH-1:0] req0_addr,
  input  logic [DATAWIDTH-1:0] req0_wdata,
  output logic                 req0_gnt,
  output logic                 req0_rvld,
  output logic [DATAWIDTH-1:0] req0_rdata,
  input  logic                 req1_vld,
  input  logic                 req1_we,
  input  logic                 req1_lock,
  input  logic [ADDRWIDTH-1:0] req1_addr,
  input  logic [DATAWIDTH-1:0] req1_wdata,
  output logic                 req1_gnt,
  output logic                 req1_rvld,
  output logic [DATAWIDTH-1:0] req1_rdata,
  output logic [ADDRWIDTH-1:0] ram_addr,
  output logic [DATAWIDTH-1:0] ram_wdata,
  output logic                 ram_we,
  input  logic [DATAWIDTH-1:0] ram_rdata,
  output logic                 arb_busy
);

  localparam int CW = $clog2(LOCK_MAX + 1);

  logic [1:0]                vld, we, lock, gnt, rvld;
  logic [1:0][ADDRWIDTH-1:0] addr;
  logic [1:0][DATAWIDTH-1:0] wdata, rdata;
  logic                      win, any_gnt;
  logic [ADDRWIDTH-1:0]      addr_q;
  logic [DATAWIDTH-1:0]      wdata_q;
  logic                      rd_pend, rd_tag;
  lock_e                     lock_st, lock_nxt;
  logic [CW-1:0]             lock_cnt, lock_cnt_nxt;

  assign vld   = {req1_vld, req0_vld};
  assign we    = {req1_we, req0_we};
  assign lock  = {req1_lock, req0_lock};
  assign addr  = {req1_addr, req0_addr};
  assign wdata = {req1_wdata, req0_wdata};

  assign {req1_gnt, req0_gnt}     = gnt;
  assign {req1_rvld, req0_rvld}   = rvld;
  assign {req1_rdata, req0_rdata} = rdata;

  assign any_gnt = |gnt;
  assign win     = gnt[1];

`ifndef SOC_RAM_ARB_FIXED_PRI_EN
  logic last_gnt;

  // Round-robin history; a forced lock break hands the next tie to the other side
  always_ff @(posedge clk or negedge rst_b)
    if (!rst_b)                                             last_gnt <= REQ1;
    else if (any_gnt)                                       last_gnt <= win;
    else if (lock_st != UNLOCKED && lock_nxt == UNLOCKED)   last_gnt <= (lock_st == LOCK1);
`endif

  soc_ram_arb_rr u_pick (
    .vld      (vld),
`ifndef SOC_RAM_ARB_FIXED_PRI_EN
    .last_gnt (last_gnt),
`endif
    .lock_st  (lock_st),
    .gnt      (gnt)
  );

  // RAM port follows the winner; address/data hold when idle so the RAM
  // keeps re-reading the same word instead of wandering
  assign ram_addr  = any_gnt ? addr[win]  : addr_q;
  assign ram_wdata = any_gnt ? wdata[win] : wdata_q;
  assign ram_we    = any_gnt & we[win];
  assign arb_busy  = any_gnt | rd_pend;

  // Lock entry on a locked grant; exit on an unlocked owner grant or budget expiry
  always_comb begin
    lock_nxt     = lock_st;
    lock_cnt_nxt = '0;
    case (lock_st)
      UNLOCKED: if (any_gnt && lock[win]) lock_nxt = win ? LOCK1 : LOCK0;
      LOCK0, LOCK1: begin
        lock_cnt_nxt = lock_cnt + 1'b1;
        if ((any_gnt && !lock[win]) || lock_cnt == CW'(LOCK_MAX - 1)) begin
          lock_nxt     = UNLOCKED;
          lock_cnt_nxt = '0;
        end
      end
      default:  lock_nxt = UNLOCKED;
    endcase
  end

  // Lock state register
  always_ff @(posedge clk or negedge rst_b)
    if (!rst_b) begin
      lock_st  <= UNLOCKED;
      lock_cnt <= '0;
    end else begin
      lock_st  <= lock_nxt;
      lock_cnt <= lock_cnt_nxt;
    end

  // Read tag pipeline plus idle hold of the RAM address/data
  always_ff @(posedge clk or negedge rst_b)
    if (!rst_b) begin
      rd_pend <= 1'b0;
      rd_tag  <= REQ0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      rd_pend <= any_gnt & ~we[win];
      if (any_gnt) begin
        rd_tag  <= win;
        addr_q  <= ram_addr;
        wdata_q <= ram_wdata;
      end
    end

  for (genvar n = 0; n < 2; n++) begin : g_ret
    logic [DATAWIDTH-1:0] held;

    assign rvld[n]  = rd_pend & (rd_tag == (n != 0 ? REQ1 : REQ0));
    assign rdata[n] = rvld[n] ? ram_rdata : held;

    // Each requester keeps its last returned word until its next return
    always_ff @(posedge clk or negedge rst_b)
      if (!rst_b)       held <= '0;
      else if (rvld[n]) held <= ram_rdata;
  end

endmodule

// File: tb/tb_soc_ram_arb.sv
// Directed bench for soc_ram_arb with a cycle-level reference model.
module tb_soc_ram_arb;
  localparam int DW = 32, AW = 14, LM = 15;
`ifdef SOC_RAM_ARB_FIXED_PRI_EN
  localparam bit [3:0] RR_SEQ = 4'b1111;
`else
  localparam bit [3:0] RR_SEQ = 4'b1010;  // bit k = winner of contended cycle k
`endif

  logic clk = 1'b0, rst_b = 1'b0;
  always #5 clk = ~clk;

  logic          req0_vld = 0, req0_we = 0, req0_lock = 0;
  logic [AW-1:0] req0_addr = '0;
  logic [DW-1:0] req0_wdata = '0;
  logic          req1_vld = 0, req1_we = 0, req1_lock = 0;
  logic [AW-1:0] req1_addr = '0;
  logic [DW-1:0] req1_wdata = '0;
  logic          req0_gnt, req0_rvld, req1_gnt, req1_rvld, ram_we, arb_busy;
  logic [DW-1:0] req0_rdata, req1_rdata, ram_wdata, ram_rdata;
  logic [AW-1:0] ram_addr;

  soc_ram_arb #(.DATAWIDTH(DW), .ADDRWIDTH(AW), .LOCK_MAX(LM)) dut (
    .clk(clk), .rst_b(rst_b),
    .req0_vld(req0_vld), .req0_we(req0_we), .req0_lock(req0_lock),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req0_gnt(req0_gnt), .req0_rvld(req0_rvld), .req0_rdata(req0_rdata),
    .req1_vld(req1_vld), .req1_we(req1_we), .req1_lock(req1_lock),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .req1_gnt(req1_gnt), .req1_rvld(req1_rvld), .req1_rdata(req1_rdata),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
    .ram_rdata(ram_rdata), .arb_busy(arb_busy)
  );

  // RAM stand-in: unwritten words read as C0DE0000+addr
  logic [DW-1:0] ram_mem[int];
  always @(posedge clk) begin
    if (ram_we) ram_mem[int'(ram_addr)] = ram_wdata;
    else ram_rdata <= ram_mem.exists(int'(ram_addr)) ? ram_mem[int'(ram_addr)]
                                                     : DW'(32'hC0DE0000 + int'(ram_addr));
  end

  int n_pass = 0, n_tot = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
  endtask

  // Reference model state
  int            own = -1, cnt = 0, last = 1, ptag = 0;
  bit            pend = 0;
  logic [DW-1:0] pdata = '0, hold0 = '0, hold1 = '0;
  logic [AW-1:0] laddr = '0;
  logic [DW-1:0] mm[int];

  function automatic logic [DW-1:0] rd_mm(input int a);
    return mm.exists(a) ? mm[a] : DW'(32'hC0DE0000 + a);
  endfunction

  always @(negedge clk) begin : model
    int w;
    logic [1:0] v, wes, lks;
    logic [AW-1:0] ad[2];
    logic [DW-1:0] wd[2];
    logic e0, e1;
    if (!rst_b) begin
      own = -1; cnt = 0; last = 1; pend = 0; hold0 = '0; hold1 = '0; laddr = '0;
      chk("rst_gnt", {req1_gnt, req0_gnt}, 0);
      chk("rst_rvld", {req1_rvld, req0_rvld}, 0);
      chk("rst_rdata", {req1_rdata, req0_rdata}, 0);
      chk("rst_we", ram_we, 0);
      chk("rst_busy", arb_busy, 0);
      chk("rst_addr", ram_addr, 0);
    end else begin
      v = {req1_vld, req0_vld}; wes = {req1_we, req0_we}; lks = {req1_lock, req0_lock};
      ad[0] = req0_addr; ad[1] = req1_addr; wd[0] = req0_wdata; wd[1] = req1_wdata;
      if (own == 0) v[1] = 1'b0;
      if (own == 1) v[0] = 1'b0;
      if (v == 2'b11) begin
`ifdef SOC_RAM_ARB_FIXED_PRI_EN
        w = 1;
`else
        w = (last == 0) ? 1 : 0;
`endif
      end else if (v[0]) w = 0;
      else if (v[1]) w = 1;
      else w = -1;
      e0 = pend && ptag == 0;
      e1 = pend && ptag == 1;
      if (e0) hold0 = pdata;
      if (e1) hold1 = pdata;
      chk("m_gnt0", req0_gnt, w == 0);
      chk("m_gnt1", req1_gnt, w == 1);
      chk("m_rvld0", req0_rvld, e0);
      chk("m_rvld1", req1_rvld, e1);
      chk("m_rdata0", req0_rdata, hold0);
      chk("m_rdata1", req1_rdata, hold1);
      chk("m_busy", arb_busy, (w >= 0) || pend);
      chk("m_we", ram_we, (w >= 0) && wes[w]);
      if (w >= 0) laddr = ad[w];
      chk("m_addr", ram_addr, laddr);
      if (w >= 0 && wes[w]) chk("m_wdata", ram_wdata, wd[w]);
      pend = 0;
      if (w >= 0) begin
        if (wes[w]) mm[int'(ad[w])] = wd[w];
        else begin pend = 1; ptag = w; pdata = rd_mm(int'(ad[w])); end
      end
      if (own < 0) begin
        if (w >= 0 && lks[w]) begin own = w; cnt = 0; end
      end else begin
        cnt++;
        if (w == own && !lks[w]) begin own = -1; cnt = 0; end
        else if (cnt == LM) begin last = own; own = -1; cnt = 0; end
      end
      if (w >= 0) last = w;
    end
  end

  task automatic step;
    @(posedge clk); #1;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin : stim
    int first, busy_n, rv_n;
    logic [DW-1:0] act;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("idle_busy", arb_busy, 0);
    chk("idle_we", ram_we, 0);
    step; rst_b = 1'b1;

    // Write then read back
    req0_vld = 1; req0_we = 1; req0_addr = 'h10; req0_wdata = 32'hDEADBEEF;
    @(negedge clk); chk("wr_gnt", req0_gnt, 1); chk("wr_we", ram_we, 1);
    step; req0_we = 0;
    @(negedge clk); chk("rd_gnt", req0_gnt, 1); chk("rd_we", ram_we, 0);
    step; req0_vld = 0;
    @(negedge clk);
    chk("rd_rvld0", req0_rvld, 1); chk("rd_data", req0_rdata, 32'hDEADBEEF);
    chk("rd_rvld1", req1_rvld, 0);
    step;
    @(negedge clk); chk("rd_hold", req0_rdata, 32'hDEADBEEF); chk("rd_rvld_off", req0_rvld, 0);
    step;

    // Asynchronous reset with a read in flight
    req1_vld = 1; req1_addr = 'h5;
    @(negedge clk); chk("ar_gnt", req1_gnt, 1);
    @(posedge clk); #1 req1_vld = 0;
    #1 chk("ar_pend", req1_rvld, 1); chk("ar_pdata", req1_rdata, 32'hC0DE0005);
    #1 rst_b = 0;
    #1 chk("ar_rvld", req1_rvld, 0); chk("ar_busy", arb_busy, 0); chk("ar_rdata", req1_rdata, 0);
    repeat (2) @(posedge clk); #1 rst_b = 1;

    // Contention from reset
    req0_vld = 1; req0_addr = 'h1; req1_vld = 1; req1_addr = 'h2;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rr_gnt1", req1_gnt, RR_SEQ[k]);
      chk("rr_gnt0", req0_gnt, !RR_SEQ[k]);
      if (k > 0) begin
        act = RR_SEQ[k-1] ? req1_rdata : req0_rdata;
        chk("rr_rvld1", req1_rvld, RR_SEQ[k-1]);
        chk("rr_data", act, 32'hC0DE0001 + 32'(RR_SEQ[k-1]));
      end
      step;
    end
    req0_vld = 0; req1_vld = 0;
    @(negedge clk);
    chk("rr_last_rvld1", req1_rvld, RR_SEQ[3]);
    step;

    // Locked read-modify-write by requester 1
    req0_vld = 1; req0_we = 1; req0_addr = 'h100; req0_wdata = 32'h41;
    @(negedge clk); chk("rmw_pre_gnt0", req0_gnt, 1);
    step;
    req0_we = 0;
    req1_vld = 1; req1_we = 0; req1_addr = 'h100; req1_lock = 1;
    @(negedge clk); chk("rmw_a_gnt1", req1_gnt, 1); chk("rmw_a_gnt0", req0_gnt, 0);
    step;
    req1_we = 1; req1_wdata = 32'h42; req1_lock = 0;
    @(negedge clk);
    chk("rmw_b_gnt1", req1_gnt, 1); chk("rmw_b_gnt0", req0_gnt, 0);
    chk("rmw_b_rvld1", req1_rvld, 1); chk("rmw_b_rdata1", req1_rdata, 32'h41);
    step;
    req1_vld = 0; req1_we = 0;
    @(negedge clk); chk("rmw_c_gnt0", req0_gnt, 1);
    step;
    req0_vld = 0;
    @(negedge clk); chk("rmw_raw_rvld0", req0_rvld, 1); chk("rmw_raw_data", req0_rdata, 32'h42);
    step;

    // Lock budget expiry
    req0_vld = 1; req0_lock = 1; req0_addr = 'h4;
    @(negedge clk); chk("to_gnt0", req0_gnt, 1);
    step;
    req1_vld = 1; req1_addr = 'h5;
    first = 0;
    for (int i = 1; i <= 40 && first == 0; i++) begin
      req0_vld = (i < 14) && (i % 2 == 0);
      req0_lock = req0_vld;
      @(negedge clk);
      if (req1_gnt) first = i;
      step;
    end
    chk("to_cycle", first, 16);
    req1_vld = 0; req0_vld = 0; req0_lock = 0;
    step; step;

    // Back-to-back reads
    busy_n = 0; rv_n = 0;
    for (int k = 0; k < 12; k++) begin
      req0_vld = (k < 8);
      req0_addr = AW'(k);
      @(negedge clk);
      if (arb_busy) busy_n++;
      if (req0_rvld) begin
        chk("pipe_data", req0_rdata, 32'hC0DE0000 + 32'(rv_n));
        rv_n++;
      end
      step;
    end
    chk("pipe_busy", busy_n, 9);
    chk("pipe_rvld", rv_n, 8);

    step;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
